// File: rtl/min_pooling_pkg.sv
// Shared definitions for the min-pooling window address generator.
//   state_t      : FSM state encoding (IDLE, RUN, DRAIN, FIN)
//   DEF_PITCH_W  : default row-pitch operand width (multiplier din0)
//   DEF_IDX_W    : default signed row-index / column-offset width (din1)
//   DEF_MUL_LAT  : default multiplier latency in ce-qualified cycles
package min_pooling_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam int DEF_PITCH_W = 62;
  localparam int DEF_IDX_W   = 32;
  localparam int DEF_MUL_LAT = 4;
endpackage

// File: rtl/min_pooling_sideband_delay.sv
// ce-gated, resettable shift register carrying tap sideband alongside the
// multiplier so it leaves aligned with the product.
//   clk, reset : clock, synchronous active-high reset (clears every stage)
//   ce         : advance enable shared with the multiplier
//   d_valid    : issue-stage valid
//   d_data     : issue-stage payload
//   q_valid    : valid after DEPTH advancing cycles
//   q_data     : payload after DEPTH advancing cycles
module min_pooling_sideband_delay #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic         d_valid,
  input  logic [W-1:0] d_data,
  output logic         q_valid,
  output logic [W-1:0] q_data
);
  logic [DEPTH-1:0]        vld_pipe;
  logic [DEPTH-1:0][W-1:0] data_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else if (ce) begin
      vld_pipe[0]  <= d_valid;
      data_pipe[0] <= d_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign q_valid = vld_pipe[DEPTH-1];
  assign q_data  = data_pipe[DEPTH-1];
endmodule

// File: rtl/min_pooling_win_addr_gen.sv
// Operand generator for the min-pooling row-address multiplier. Walks
// oy / ox / ky / kx (kx innermost), presents one (pitch, row index) pair per
// advancing cycle and delays column/window flags to line up with the product.
//   clk, reset, ce       : clock, sync active-high reset, global advance enable
//   start                : begin frame (IDLE, ce=1 only)
//   out_h, out_w         : output rows / columns, latched on start
//   row_pitch            : bytes per row, latched on start
//   mul_din0, mul_din1   : multiplier operands (pitch, oy*STRIDE+ky)
//   prod_valid/col/...   : sideband aligned with the multiplier output
//   busy, done           : frame in progress / frame-complete pulse
module min_pooling_win_addr_gen
  import min_pooling_pkg::*;
#(
  parameter int PITCH_W = DEF_PITCH_W,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int KSIZE   = 2,
  parameter int STRIDE  = 2,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               start,
  input  logic [IDX_W-1:0]   out_h,
  input  logic [IDX_W-1:0]   out_w,
  input  logic [PITCH_W-1:0] row_pitch,
  output logic [PITCH_W-1:0] mul_din0,
  output logic [IDX_W-1:0]   mul_din1,
  output logic               prod_valid,
  output logic [IDX_W-1:0]   prod_col,
  output logic               prod_win_first,
  output logic               prod_win_last,
  output logic               busy,
  output logic               done
);
  localparam int KW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [KW-1:0]    KMAX    = KW'(KSIZE - 1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(MUL_LAT - 1);
  localparam logic [IDX_W-1:0] STEP    = IDX_W'(STRIDE);

  state_t           state;
  logic [IDX_W-1:0] h_lat, w_lat, oy, ox, row_base, col_base;
  logic [KW-1:0]    ky, kx;
  logic [CW-1:0]    drain_cnt;
  logic             kx_end, ky_end, ox_end, oy_end, last_tap;
  logic             iss_valid, iss_first, iss_last;
  logic [IDX_W-1:0] iss_col;
  logic [IDX_W+1:0] sb_q;

  assign kx_end   = (kx == KMAX);
  assign ky_end   = (ky == KMAX);
  assign ox_end   = (ox == w_lat - 1'b1);
  assign oy_end   = (oy == h_lat - 1'b1);
  assign last_tap = kx_end && ky_end && ox_end && oy_end;

  // Row/col bases are stepped by STRIDE, so the tap index is just base + k.
  assign mul_din1  = row_base + IDX_W'(ky);
  assign iss_col   = col_base + IDX_W'(kx);
  assign iss_valid = (state == RUN);
  assign iss_first = iss_valid && (ky == '0) && (kx == '0);
  assign iss_last  = iss_valid && ky_end && kx_end;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      h_lat     <= '0;
      w_lat     <= '0;
      mul_din0  <= '0;
      oy        <= '0;
      ox        <= '0;
      ky        <= '0;
      kx        <= '0;
      row_base  <= '0;
      col_base  <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: if (start) begin
          h_lat    <= out_h;
          w_lat    <= out_w;
          mul_din0 <= row_pitch;
          oy       <= '0;
          ox       <= '0;
          ky       <= '0;
          kx       <= '0;
          row_base <= '0;
          col_base <= '0;
          state    <= (out_h == '0 || out_w == '0) ? FIN : RUN;
        end
        RUN: begin
          // Counters freeze on the last tap so mul_din1 holds through DRAIN.
          if (last_tap) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end else if (!kx_end) begin
            kx <= kx + 1'b1;
          end else begin
            kx <= '0;
            if (!ky_end) begin
              ky <= ky + 1'b1;
            end else begin
              ky <= '0;
              if (!ox_end) begin
                ox       <= ox + 1'b1;
                col_base <= col_base + STEP;
              end else begin
                ox       <= '0;
                col_base <= '0;
                oy       <= oy + 1'b1;
                row_base <= row_base + STEP;
              end
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == CNT_MAX) state <= FIN;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        FIN: begin
          // First FIN cycle registers the pulse, second one emits it and leaves.
          if (!done) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  min_pooling_sideband_delay #(
    .W     (IDX_W + 2),
    .DEPTH (MUL_LAT)
  ) u_sideband (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .d_valid (iss_valid),
    .d_data  ({iss_col, iss_first, iss_last}),
    .q_valid (prod_valid),
    .q_data  (sb_q)
  );

  assign prod_col       = sb_q[IDX_W+1:2];
  assign prod_win_first = sb_q[1];
  assign prod_win_last  = sb_q[0];
endmodule

// File: tb/tb_min_pooling_win_addr_gen.sv
module tb_min_pooling_win_addr_gen;
  localparam int PW = 62;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset, ce, start, start2;
  logic [IW-1:0] out_h, out_w, out_h2, out_w2;
  logic [PW-1:0] row_pitch, row_pitch2;
  logic [PW-1:0] mul_din0, k1_din0;
  logic [IW-1:0] mul_din1, k1_din1, prod_col, k1_col;
  logic          prod_valid, prod_win_first, prod_win_last, busy, done;
  logic          k1_valid, k1_first, k1_last, k1_busy, k1_done;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  min_pooling_win_addr_gen dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start),
    .out_h(out_h), .out_w(out_w), .row_pitch(row_pitch),
    .mul_din0(mul_din0), .mul_din1(mul_din1),
    .prod_valid(prod_valid), .prod_col(prod_col),
    .prod_win_first(prod_win_first), .prod_win_last(prod_win_last),
    .busy(busy), .done(done)
  );

  min_pooling_win_addr_gen #(.KSIZE(1), .STRIDE(1)) dut_k1 (
    .clk(clk), .reset(reset), .ce(ce), .start(start2),
    .out_h(out_h2), .out_w(out_w2), .row_pitch(row_pitch2),
    .mul_din0(k1_din0), .mul_din1(k1_din1),
    .prod_valid(k1_valid), .prod_col(k1_col),
    .prod_win_first(k1_first), .prod_win_last(k1_last),
    .busy(k1_busy), .done(k1_done)
  );

  // Model multiplier: 62-bit unsigned x 32-bit signed, 4 ce-qualified stages.
  logic        [63:0] mpipe [4];
  logic signed [63:0] opa, opb;
  always_comb begin
    opa = {2'b00, mul_din0};
    opb = {{32{mul_din1[31]}}, mul_din1};
  end
  always @(posedge clk) begin
    if (ce) begin
      mpipe[0] <= opa * opb;
      for (int i = 1; i < 4; i++) mpipe[i] <= mpipe[i-1];
    end
  end

  // Each product is consumed on the ce=1 cycle that retires it.
  logic [IW-1:0] m_col[$];
  bit            m_first[$], m_last[$];
  logic [63:0]   m_prod[$];
  logic [IW-1:0] e_col[$];
  bit            e_first[$], e_last[$];
  logic [63:0]   e_prod[$];

  always @(negedge clk) begin
    if (!reset && ce) begin
      if (prod_valid) begin
        m_col.push_back(prod_col);
        m_first.push_back(prod_win_first);
        m_last.push_back(prod_win_last);
        m_prod.push_back(mpipe[3]);
      end
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    m_col.delete(); m_first.delete(); m_last.delete(); m_prod.delete();
  endtask

  // Expected tap stream for KSIZE=2, STRIDE=2 from the plain loop nest.
  task automatic build_exp(input int h, input int w, input logic [PW-1:0] pitch);
    e_col.delete(); e_first.delete(); e_last.delete(); e_prod.delete();
    for (int oy = 0; oy < h; oy++)
      for (int ox = 0; ox < w; ox++)
        for (int ky = 0; ky < 2; ky++)
          for (int kx = 0; kx < 2; kx++) begin
            e_col.push_back(IW'(ox * 2 + kx));
            e_first.push_back(ky == 0 && kx == 0);
            e_last.push_back(ky == 1 && kx == 1);
            e_prod.push_back(64'(oy * 2 + ky) * 64'(pitch));
          end
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rnd) ce = 1'($urandom_range(0, 1));
      step();
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
    ce = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; start = 1'b0; start2 = 1'b0;
    out_h = '0; out_w = '0; row_pitch = '0;
    out_h2 = '0; out_w2 = '0; row_pitch2 = '0;
    repeat (3) step();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_chk++; if (prod_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", prod_valid); end
    n_chk++; if (mul_din0 !== '0) begin n_fail++; $display("FAIL reset_din0 got=%0d exp=0", mul_din0); end
    n_chk++; if (mul_din1 !== '0) begin n_fail++; $display("FAIL reset_din1 got=%0d exp=0", mul_din1); end
    n_chk++; if ({prod_col, prod_win_first, prod_win_last} !== '0) begin
      n_fail++; $display("FAIL reset_sideband got=%0h exp=0", {prod_col, prod_win_first, prod_win_last});
    end
    n_chk++; if ({k1_busy, k1_valid, k1_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_k1 got=%b exp=000", {k1_busy, k1_valid, k1_done});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_window();
    int exp_row[4];
    int exp_col[4];
    exp_row = '{0, 0, 1, 1};
    exp_col = '{0, 1, 0, 1};
    out_h = 1; out_w = 1; row_pitch = 100;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k <= 4) begin
        n_chk++; if (mul_din1 !== IW'(exp_row[k-1])) begin
          n_fail++; $display("FAIL single_din1 cyc%0d got=%0d exp=%0d", k, mul_din1, exp_row[k-1]);
        end
        n_chk++; if (mul_din0 !== PW'(100)) begin
          n_fail++; $display("FAIL single_din0 cyc%0d got=%0d exp=100", k, mul_din0);
        end
      end
      n_chk++; if (prod_valid !== 1'(k >= 5 && k <= 8)) begin
        n_fail++; $display("FAIL single_valid cyc%0d got=%b", k, prod_valid);
      end
      if (k >= 5 && k <= 8) begin
        n_chk++; if (prod_col !== IW'(exp_col[k-5]) || prod_win_first !== 1'(k == 5) || prod_win_last !== 1'(k == 8)) begin
          n_fail++; $display("FAIL single_side cyc%0d got col=%0d f=%b l=%b exp col=%0d", k, prod_col, prod_win_first, prod_win_last, exp_col[k-5]);
        end
        n_chk++; if (mpipe[3] !== 64'(exp_row[k-5] * 100)) begin
          n_fail++; $display("FAIL single_prod cyc%0d got=%0d exp=%0d", k, mpipe[3], exp_row[k-5] * 100);
        end
      end
      n_chk++; if (done !== 1'(k == 10) || busy !== 1'(k <= 10)) begin
        n_fail++; $display("FAIL single_ctrl cyc%0d got done=%b busy=%b", k, done, busy);
      end
      step();
    end
  endtask

  task automatic test_multi_window();
    bit ok;
    int d0;
    build_exp(2, 3, 62'h1_0000_0003);
    clear_mon();
    d0 = done_cnt;
    out_h = 2; out_w = 3; row_pitch = 62'h1_0000_0003;
    start = 1'b1; step(); start = 1'b0;
    wait_done(200, 1'b0, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL multi_timeout got=no_done exp=done"); end
    n_chk++; if (m_col.size() != 24) begin n_fail++; $display("FAIL multi_count got=%0d exp=24", m_col.size()); end
    for (int t = 0; t < 24 && t < m_col.size(); t++) begin
      n_chk++;
      if (m_col[t] !== e_col[t] || m_first[t] !== e_first[t] || m_last[t] !== e_last[t] || m_prod[t] !== e_prod[t]) begin
        n_fail++;
        $display("FAIL multi_tap%0d got col=%0d f=%b l=%b p=%0h exp col=%0d f=%b l=%b p=%0h",
                 t, m_col[t], m_first[t], m_last[t], m_prod[t], e_col[t], e_first[t], e_last[t], e_prod[t]);
      end
    end
    step();
    n_chk++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL multi_end got pulses=%0d busy=%b exp 1/0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_random_ce();
    bit ok;
    build_exp(2, 3, 12345);
    clear_mon();
    out_h = 2; out_w = 3; row_pitch = 12345;
    ce = 1'b1; start = 1'b1; step(); start = 1'b0;
    wait_done(600, 1'b1, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rnd_timeout got=no_done exp=done"); end
    n_chk++; if (m_col.size() != 24) begin n_fail++; $display("FAIL rnd_count got=%0d exp=24", m_col.size()); end
    for (int t = 0; t < 24 && t < m_col.size(); t++) begin
      n_chk++;
      if (m_col[t] !== e_col[t] || m_first[t] !== e_first[t] || m_last[t] !== e_last[t] || m_prod[t] !== e_prod[t]) begin
        n_fail++;
        $display("FAIL rnd_tap%0d got col=%0d p=%0d exp col=%0d p=%0d", t, m_col[t], m_prod[t], e_col[t], e_prod[t]);
      end
    end
    step();
  endtask

  task automatic test_zero_dim();
    int d0;
    clear_mon();
    d0 = done_cnt;
    out_h = 2; out_w = 0; row_pitch = 5;
    start = 1'b1; step();
    for (int k = 1; k <= 4; k++) begin
      n_chk++; if (busy !== 1'(k <= 2) || done !== 1'(k == 2) || prod_valid !== 1'b0) begin
        n_fail++; $display("FAIL zero_cyc%0d got busy=%b done=%b valid=%b", k, busy, done, prod_valid);
      end
      start = (k == 1); // pulse while busy must be ignored
      out_w = 3;
      step();
    end
    start = 1'b0;
    n_chk++; if (done_cnt - d0 != 1 || m_col.size() != 0) begin
      n_fail++; $display("FAIL zero_totals got pulses=%0d taps=%0d exp 1/0", done_cnt - d0, m_col.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0;
    out_h = 2; out_w = 3; row_pitch = 77;
    start = 1'b1; step(); start = 1'b0;
    repeat (10) step();             // tap 10 is now on the operand bus
    d0 = done_cnt;
    reset = 1'b1; step(); reset = 1'b0;
    n_chk++; if (prod_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_state got valid=%b busy=%b done=%b exp 000", prod_valid, busy, done);
    end
    repeat (12) step();
    n_chk++; if (done_cnt != d0) begin n_fail++; $display("FAIL rstmid_nodone got=%0d exp=%0d", done_cnt, d0); end
    build_exp(2, 3, 77);
    clear_mon();
    start = 1'b1; step(); start = 1'b0;
    wait_done(200, 1'b0, ok);
    n_chk++; if (!ok || m_col.size() != 24) begin
      n_fail++; $display("FAIL rstmid_replay got ok=%b taps=%0d exp 1/24", ok, m_col.size());
    end
    for (int t = 0; t < 24 && t < m_col.size(); t++) begin
      n_chk++;
      if (m_col[t] !== e_col[t] || m_first[t] !== e_first[t] || m_last[t] !== e_last[t] || m_prod[t] !== e_prod[t]) begin
        n_fail++; $display("FAIL rstmid_tap%0d got col=%0d p=%0d exp col=%0d p=%0d", t, m_col[t], m_prod[t], e_col[t], e_prod[t]);
      end
    end
    step();
  endtask

  task automatic test_ksize1();
    int exp_row[4];
    int exp_col[4];
    exp_row = '{0, 0, 1, 1};
    exp_col = '{0, 1, 0, 1};
    out_h2 = 2; out_w2 = 2; row_pitch2 = 7;
    start2 = 1'b1; step(); start2 = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k <= 4) begin
        n_chk++; if (k1_din1 !== IW'(exp_row[k-1])) begin
          n_fail++; $display("FAIL k1_din1 cyc%0d got=%0d exp=%0d", k, k1_din1, exp_row[k-1]);
        end
      end
      n_chk++; if (k1_valid !== 1'(k >= 5 && k <= 8)) begin
        n_fail++; $display("FAIL k1_valid cyc%0d got=%b", k, k1_valid);
      end
      if (k >= 5 && k <= 8) begin
        n_chk++; if (k1_col !== IW'(exp_col[k-5]) || k1_first !== 1'b1 || k1_last !== 1'b1) begin
          n_fail++; $display("FAIL k1_side cyc%0d got col=%0d f=%b l=%b exp col=%0d f=1 l=1", k, k1_col, k1_first, k1_last, exp_col[k-5]);
        end
      end
      n_chk++; if (k1_done !== 1'(k == 10)) begin
        n_fail++; $display("FAIL k1_done cyc%0d got=%b", k, k1_done);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_multi_window();
    test_random_ce();
    test_zero_dim();
    test_reset_mid();
    test_ksize1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
